// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with a main entry and a skid entry.
// Latency: one cycle from acceptance to out_data/out_valid; full throughput.
// Backpressure: in_ready is a registered-state decode, never a function of out_ready.
module pipe_skid_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   // Encoding equals the number of held entries, so count is the state register itself.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;

   logic in_fire;
   logic out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // State register; reset wins over flush and any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-data decode. Flush writes no data registers, so any
   // same-cycle input is dropped while the delivered output simply counts as gone.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  main_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  // Downstream stalled: park the newcomer behind the main entry.
                  skid_d  = in_data;
                  state_d = ST_FULL;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // Data registers; reset loads the configured value into both entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   // Output decode, purely from the registered state (plus rst gating in_ready).
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = (state_q != ST_FULL) & ~rst;
      out_data  = main_q;
      count     = state_q;
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based model.
// Outputs are compared on the falling edge; inputs change 1 time unit after the rising edge.
// The model holds at most two entries; acceptance is decided from the model, not the DUT.
module tb_pipe_skid_reg;

   localparam int          W    = 32;
   localparam logic [31:0] RVAL = 32'hDEADBEEF;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [1:0]    count;

   int n_tests;
   int n_fail;

   // Reference model: the held entries in arrival order, plus the last head value.
   logic [W-1:0] mq[$];
   logic [W-1:0] main_m;
   bit           known;

   pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance the model.
   task automatic cycle(input bit r, input bit f, input bit iv, input logic [W-1:0] d,
                        input bit ordy, output bit acc);
      bit exp_ovld, exp_irdy, out_f;
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(negedge clk);
      exp_ovld = (mq.size() > 0);
      exp_irdy = (mq.size() < 2) && !r;
      if (known) begin
         check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_ovld});
         check_eq("in_ready",  {31'd0, in_ready},  {31'd0, exp_irdy});
         check_eq("count",     {30'd0, count},     mq.size());
         check_eq("out_data",  out_data,           main_m);
      end
      acc   = known && iv && exp_irdy;
      out_f = known && exp_ovld && ordy;
      @(posedge clk);
      if (r) begin
         mq.delete();
         main_m = RVAL;
         known  = 1'b1;
      end else if (known) begin
         if (out_f) void'(mq.pop_front());
         if (f) mq.delete();
         else if (acc) mq.push_back(d);
         if (mq.size() > 0) main_m = mq[0];
      end
      #1;
   endtask

   initial begin
      bit acc;
      bit got_a3;
      logic [W-1:0] v;
      n_tests = 0;
      n_fail  = 0;
      known   = 1'b0;
      main_m  = '0;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // 1. Reset for two cycles then idle.
      cycle(1, 0, 0, '0, 0, acc);
      cycle(1, 0, 0, '0, 0, acc);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("idle_in_ready",  {31'd0, in_ready},  32'd1);
      check_eq("idle_count",     {30'd0, count},     32'd0);
      check_eq("idle_out_data",  out_data,           RVAL);
      @(posedge clk); #1;

      // 2. Streaming with downstream always ready.
      for (int i = 1; i <= 8; i++) begin
         cycle(0, 0, 1, W'(i), 1, acc);
         check_eq("stream_accept", {31'd0, acc}, 32'd1);
      end
      cycle(0, 0, 0, '0, 1, acc);
      cycle(0, 0, 0, '0, 1, acc);

      // 3. Backpressure into the skid entry, then drain.
      cycle(0, 0, 1, 32'hA1, 0, acc);
      cycle(0, 0, 1, 32'hA2, 0, acc);
      @(negedge clk);
      check_eq("skid_count",    {30'd0, count},    32'd2);
      check_eq("skid_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      cycle(0, 0, 1, 32'hA3, 0, acc);
      check_eq("a3_refused", {31'd0, acc}, 32'd0);
      got_a3 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, !got_a3, 32'hA3, 1, acc);
         if (acc) got_a3 = 1'b1;
      end
      check_eq("a3_accepted", {31'd0, got_a3}, 32'd1);

      // 4. Flush while full with an input offered in the same cycle.
      cycle(0, 0, 1, 32'h11, 0, acc);
      cycle(0, 0, 1, 32'h22, 0, acc);
      cycle(0, 1, 1, 32'h33, 0, acc);
      @(negedge clk);
      check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("flush_count",     {30'd0, count},     32'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, acc);

      // 5. Reset mid-operation with flush and out_ready also asserted.
      cycle(0, 0, 1, 32'h55, 0, acc);
      cycle(0, 0, 1, 32'h66, 0, acc);
      cycle(1, 1, 1, 32'h77, 1, acc);
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("rst_mid_out_data",  out_data,           RVAL);
      check_eq("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
      @(posedge clk); #1;

      // 6. Random valid/ready traffic without flush.
      for (int i = 0; i < 10000; i++) begin
         v = $urandom;
         cycle(0, 0, ($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) != 0), acc);
      end

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 1000; i++) begin
         v = $urandom;
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
               $urandom_range(0, 1) == 1, v, $urandom_range(0, 1) == 1, acc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
